// File: rtl/spi_xfer_ctrl.sv
// Frame-level SPI transfer sequencer: buffers TX bytes, drives chip select and
// hands one byte at a time to an external spi_master, returning received bytes.
module spi_xfer_ctrl #(
  parameter int SETUP_CYC = 1,
  parameter int GAP_CYC   = 2,
  parameter int TX_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_last,
  output logic [7:0] m_mosi_in,
  output logic       m_start,
  input  logic [7:0] m_miso_out,
  input  logic       m_done,
  output logic       cs,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  localparam int          AW         = $clog2(TX_DEPTH);
  localparam logic [AW:0] DEPTH_C    = (AW+1)'(TX_DEPTH);
  localparam logic [3:0]  SETUP_LAST = 4'(SETUP_CYC - 1);
  localparam logic [3:0]  GAP_LAST   = 4'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_START,
    S_WAIT_DONE,
    S_NEXT,
    S_HOLD,
    S_GAP
  } state_t;

  logic [8:0]    r_mem [TX_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_rdy_en;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic          r_cs;
  logic [7:0]    r_mosi;
  logic          r_last;
  logic [7:0]    r_rx_data;
  logic          r_rx_valid;
  logic          r_rx_last;
  logic [7:0]    r_frame_cnt;

  state_t        w_state_nxt;
  logic [3:0]    w_cnt_nxt;
  logic          w_cs_nxt;
  logic          w_load;
  logic          w_frame_inc;
  logic          w_rx_cap;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic [8:0]    w_head;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == DEPTH_C);
  assign tx_ready = r_rdy_en && !w_full;
  assign w_push   = tx_valid && tx_ready;
  assign w_pop    = (r_state == S_START);
  assign w_head   = r_mem[r_rptr];
  assign w_rx_cap = (r_state == S_WAIT_DONE) && m_done;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {tx_last, tx_data};
  end

  // tx_ready stays low while in reset and rises on the first edge after release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cs_nxt    = r_cs;
    w_load      = 1'b0;
    w_frame_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = S_SETUP;
          w_cs_nxt    = 1'b0;
          w_cnt_nxt   = '0;
        end
      end
      S_SETUP: begin
        if (r_cnt == SETUP_LAST) begin
          w_state_nxt = S_START;
          w_load      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_START: w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (m_done) w_state_nxt = r_last ? S_HOLD : S_NEXT;
      end
      // An empty FIFO here is an underrun: wait indefinitely with cs held low
      S_NEXT: begin
        if (!w_empty) begin
          w_state_nxt = S_START;
          w_load      = 1'b1;
        end
      end
      S_HOLD: begin
        w_state_nxt = S_GAP;
        w_cs_nxt    = 1'b1;
        w_frame_inc = 1'b1;
        w_cnt_nxt   = '0;
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) w_state_nxt = S_IDLE;
        else                   w_cnt_nxt   = r_cnt + 4'd1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cs_nxt    = 1'b1;
      end
    endcase
  end

  // The byte is loaded on entry to START so it is already stable while m_start is high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cs        <= 1'b1;
      r_mosi      <= '0;
      r_last      <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_rx_last   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cs       <= w_cs_nxt;
      r_rx_valid <= w_rx_cap;
      r_rx_last  <= w_rx_cap && r_last;
      if (w_load) begin
        r_last <= w_head[8];
        r_mosi <= w_head[7:0];
      end
      if (w_rx_cap)    r_rx_data   <= m_miso_out;
      if (w_frame_inc) r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign m_start   = (r_state == S_START);
  assign busy      = (r_state != S_IDLE);
  assign cs        = r_cs;
  assign m_mosi_in = r_mosi;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign rx_last   = r_rx_last;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl with a stub spi_master that answers
// each byte with (mosi ^ 0x99) ten cycles after m_start.
module tb_spi_xfer_ctrl;

  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_last = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_last;
  logic [7:0] m_mosi_in;
  logic       m_start;
  logic [7:0] m_miso_out;
  logic       m_done;
  logic       cs;
  logic       busy;
  logic [7:0] frame_cnt;

  logic       stub_done = 1'b0;
  logic       inj_done  = 1'b0;
  logic       stall     = 1'b0;
  logic       stub_act  = 1'b0;
  logic [7:0] stub_mosi = '0;
  logic [7:0] stub_miso = '0;
  int         stub_cnt  = 0;

  int n_chk = 0;
  int n_fail = 0;

  int n_start = 0, n_rx = 0, n_rxl = 0, n_rise = 0, n_b2b = 0, n_start_cs = 0;
  int min_gap = 1000, hi_run = 0;
  logic prev_start = 1'b0, prev_cs = 1'b1, seen_rise = 1'b0;
  logic [7:0] last_rxl_data = '0;
  logic [7:0] q_rx[$];
  logic [7:0] q_mosi[$];

  assign m_done     = stub_done | inj_done;
  assign m_miso_out = stub_miso;

  spi_xfer_ctrl #(.SETUP_CYC(1), .GAP_CYC(GAP), .TX_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last),
    .m_mosi_in(m_mosi_in), .m_start(m_start), .m_miso_out(m_miso_out), .m_done(m_done),
    .cs(cs), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    stub_done = 1'b0;
    if (!rst) begin
      stub_act = 1'b0;
      stub_cnt = 0;
    end else if (stub_act) begin
      if (stub_cnt > 0) stub_cnt--;
      else if (!stall) begin
        stub_done = 1'b1;
        stub_miso = stub_mosi ^ 8'h99;
        stub_act  = 1'b0;
      end
    end else if (m_start) begin
      stub_act  = 1'b1;
      stub_mosi = m_mosi_in;
      stub_cnt  = 9;
    end
  end

  always @(negedge clk) begin
    if (m_start) begin
      n_start++;
      q_mosi.push_back(m_mosi_in);
      if (prev_start) n_b2b++;
      if (cs) n_start_cs++;
    end
    prev_start = m_start;
    if (rx_valid) begin
      n_rx++;
      q_rx.push_back(rx_data);
      if (rx_last) begin
        n_rxl++;
        last_rxl_data = rx_data;
      end
    end
    if (cs) hi_run++;
    else begin
      if (prev_cs && seen_rise && hi_run < min_gap) min_gap = hi_run;
      hi_run = 0;
    end
    if (cs && !prev_cs) begin
      n_rise++;
      seen_rise = 1'b1;
    end
    prev_cs = cs;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    int t = 0;
    tx_data  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    while (!tx_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("push_accept", 32'(t < 500), 32'd1);
    if (tx_ready) begin
      @(posedge clk);
      @(negedge clk);
    end
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input logic [7:0] target);
    int t = 0;
    while (!(frame_cnt == target && !busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("wait_idle", 32'(t < 3000), 32'd1);
  endtask

  task automatic wait_start(input int base);
    int t = 0;
    while (n_start == base && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("wait_start", 32'(t < 50), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_start, b_rx, b_rxl, b_rise, b_q, b_m, t;

    #1 rst = 1'b0;
    #1;
    chk("rst_cs", cs, 1);
    chk("rst_m_start", m_start, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_last", rx_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_mosi", m_mosi_in, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rdy_after_release", tx_ready, 1);

    // single byte frame and first-byte latency
    b_start = n_start; b_rx = n_rx; b_rxl = n_rxl; b_q = q_rx.size();
    push(8'h5A, 1'b1);
    chk("lat_cs_still_high", cs, 1);
    @(negedge clk);
    chk("lat_cs_low", cs, 0);
    chk("lat_no_start_yet", m_start, 0);
    @(negedge clk);
    chk("lat_start", m_start, 1);
    chk("lat_mosi", m_mosi_in, 8'h5A);
    wait_idle(8'd1);
    chk("one_starts", n_start - b_start, 1);
    chk("one_rx_cnt", n_rx - b_rx, 1);
    chk("one_rxl_cnt", n_rxl - b_rxl, 1);
    chk("one_rx_byte", q_rx[b_q], 8'hC3);
    chk("one_rx_data_held", rx_data, 8'hC3);
    chk("one_cs_high", cs, 1);
    chk("one_frame_cnt", frame_cnt, 1);

    // three byte frame
    b_start = n_start; b_rx = n_rx; b_rxl = n_rxl; b_rise = n_rise; b_q = q_rx.size();
    push(8'h01, 1'b0);
    push(8'h02, 1'b0);
    push(8'h03, 1'b1);
    wait_idle(8'd2);
    chk("three_starts", n_start - b_start, 3);
    chk("three_rx_cnt", n_rx - b_rx, 3);
    chk("three_rxl_cnt", n_rxl - b_rxl, 1);
    chk("three_rxl_byte", last_rxl_data, 8'h9A);
    chk("three_cs_rises", n_rise - b_rise, 1);
    chk("three_rx0", q_rx[b_q], 8'h98);
    chk("three_rx1", q_rx[b_q+1], 8'h9B);
    chk("three_rx2", q_rx[b_q+2], 8'h9A);

    // underrun stall in NEXT
    b_start = n_start; b_rx = n_rx; b_rxl = n_rxl; b_rise = n_rise;
    push(8'h11, 1'b0);
    repeat (20) @(negedge clk);
    chk("stall_busy", busy, 1);
    chk("stall_cs_low", cs, 0);
    chk("stall_no_start", m_start, 0);
    chk("stall_starts", n_start - b_start, 1);
    chk("stall_rx_cnt", n_rx - b_rx, 1);
    chk("stall_frame_cnt", frame_cnt, 2);
    push(8'h22, 1'b1);
    wait_idle(8'd3);
    chk("stall_starts_end", n_start - b_start, 2);
    chk("stall_rxl_cnt", n_rxl - b_rxl, 1);
    chk("stall_cs_rises", n_rise - b_rise, 1);
    chk("stall_frame_end", frame_cnt, 3);

    // FIFO full while master is stalled
    stall = 1'b1;
    b_start = n_start; b_rx = n_rx; b_q = q_rx.size(); b_m = q_mosi.size();
    push(8'hA0, 1'b0);
    wait_start(b_start);
    for (int i = 1; i <= 4; i++) push(8'hA0 + 8'(i), 1'b0);
    chk("full_ready_low", tx_ready, 0);
    tx_data  = 8'hA5;
    tx_last  = 1'b1;
    tx_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("full_ready_hold", tx_ready, 0);
    stall = 1'b0;
    push(8'hA5, 1'b1);
    wait_idle(8'd4);
    chk("full_starts", n_start - b_start, 6);
    chk("full_rx_cnt", n_rx - b_rx, 6);
    for (int i = 0; i < 6; i++) begin
      chk("full_mosi_order", q_mosi[b_m+i], 8'hA0 + 8'(i));
      chk("full_rx_order", q_rx[b_q+i], (8'hA0 + 8'(i)) ^ 8'h99);
    end

    // reset while waiting for the master
    b_start = n_start; b_rx = n_rx;
    push(8'h77, 1'b1);
    wait_start(b_start);
    repeat (3) @(negedge clk);
    chk("abort_busy", busy, 1);
    chk("abort_cs_low", cs, 0);
    #1 rst = 1'b0;
    #1;
    chk("abort_cs_async", cs, 1);
    chk("abort_busy_async", busy, 0);
    chk("abort_start_async", m_start, 0);
    chk("abort_frame_cnt", frame_cnt, 0);
    chk("abort_rx_data", rx_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_no_rx", n_rx - b_rx, 0);
    chk("abort_frame_after", frame_cnt, 0);
    chk("abort_cs_after", cs, 1);
    chk("abort_idle_after", busy, 0);
    chk("abort_ready_after", tx_ready, 1);

    // 256 single-byte frames, frame counter wraps
    b_rx = n_rx; b_rxl = n_rxl; b_rise = n_rise;
    for (int i = 0; i < 256; i++) push(8'(i), 1'b1);
    t = 0;
    while (!((n_rx - b_rx) == 256 && !busy) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("wrap_done", 32'(t < 20000), 32'd1);
    chk("wrap_frame_cnt", frame_cnt, 0);
    chk("wrap_rx_cnt", n_rx - b_rx, 256);
    chk("wrap_rxl_cnt", n_rxl - b_rxl, 256);
    chk("wrap_cs_rises", n_rise - b_rise, 256);
    chk("no_b2b_start", n_b2b, 0);
    chk("no_start_cs_high", n_start_cs, 0);
    chk("gap_min", 32'(min_gap >= GAP), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
